axi_slave: RTL and testbench

AXI_SLAVE -- requirements
Module: axi_slave

---
 rtl/axi_pkg.sv | 36 +++
 rtl/axi_slave_regfile.sv | 51 +++++
 rtl/axi_slave.sv | 173 +++++++++++++++++
 tb/tb_axi_slave.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// ----------------------------------------------------------------------------
// axi_pkg
// Shared widths, address map constants, response codes and FSM state types
// for the small AXI-style register slave and its storage sub-module.
// ----------------------------------------------------------------------------
package axi_pkg;

   localparam int ADDR_W   = 3;
   localparam int DATA_W   = 4;
   localparam int NUM_REGS = 7;   // writable registers live at addresses 0..6

   localparam logic [ADDR_W-1:0] ID_ADDR  = 3'd7;
   localparam logic [DATA_W-1:0] ID_VALUE = 4'hA;

   localparam logic RESP_OKAY = 1'b0;
   localparam logic RESP_ERR  = 1'b1;

   typedef enum logic [1:0] {
      W_IDLE      = 2'd0,
      W_WAIT_DATA = 2'd1,   // address captured, waiting for data
      W_WAIT_ADDR = 2'd2,   // data captured, waiting for address
      W_RESP      = 2'd3    // write committed, response pending
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_t;

   // A write is refused when no byte is enabled or it targets the ID register.
   function automatic logic write_resp(input logic               strb,
                                       input logic [ADDR_W-1:0] addr);
      return (!strb || (addr == ID_ADDR)) ? RESP_ERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_slave_regfile.sv
// ----------------------------------------------------------------------------
// axi_slave_regfile
// Seven 4-bit registers plus a constant ID register at the top address.
// One synchronous write port, one combinational read port.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   async active-high reset, clears all registers
//   we     in   write enable (ignored for the ID address)
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (current contents, i.e. pre-write on a write edge)
// ----------------------------------------------------------------------------
module axi_slave_regfile
   import axi_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [NUM_REGS];

   // NOTE: this storage is small enough to live in flops, so it is cleared by
   // reset; a RAM-mapped array would have to be left without a reset.
   // NOTE: state is updated with non-blocking assignments so every register
   // samples its inputs from before the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (waddr != ID_ADDR)) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      if (raddr == ID_ADDR) begin
         rdata = ID_VALUE;
      end else begin
         rdata = mem[raddr];
      end
   end

endmodule

// File: rtl/axi_slave.sv
// ----------------------------------------------------------------------------
// axi_slave
// Minimal AXI-style register slave: independent write address / write data
// channels with a write response, and a read address channel with read data.
// Write and read paths run concurrently.
//
// Ports:
//   clk, reset                       clock, async active-high reset
//   wa_valid/wa_addr/wa_ready        write address channel
//   wd_valid/wd_data/wd_strb/wd_ready write data channel
//   b_valid/b_response/b_ready       write response channel
//   ra_valid/ra_addr/ra_ready        read address channel
//   rd_valid/rd_data/rd_response/rd_ready read data channel
// ----------------------------------------------------------------------------
module axi_slave
   import axi_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wa_valid,
   input  logic [ADDR_W-1:0] wa_addr,
   output logic              wa_ready,
   input  logic              wd_valid,
   input  logic [DATA_W-1:0] wd_data,
   input  logic              wd_strb,
   output logic              wd_ready,
   output logic              b_valid,
   output logic              b_response,
   input  logic              b_ready,
   input  logic              ra_valid,
   input  logic [ADDR_W-1:0] ra_addr,
   output logic              ra_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_response,
   input  logic              rd_ready
);

   // ---------------------------------------------------------------- write --
   w_state_t          w_state, w_next;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_data;
   logic              cap_strb;
   logic              b_resp_q;
   logic              wa_hs, wd_hs, commit;
   logic [ADDR_W-1:0] eff_addr;
   logic [DATA_W-1:0] eff_data;
   logic              eff_strb;

   assign wa_hs = wa_valid && wa_ready;
   assign wd_hs = wd_valid && wd_ready;

   // The commit edge may coincide with the last handshake, so use the live
   // channel value for whichever half arrives on that edge.
   assign eff_addr = wa_hs ? wa_addr : cap_addr;
   assign eff_data = wd_hs ? wd_data : cap_data;
   assign eff_strb = wd_hs ? wd_strb : cap_strb;

   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves it unassigned and no latch is inferred.
   always_comb begin
      w_next   = w_state;
      wa_ready = 1'b0;
      wd_ready = 1'b0;
      b_valid  = 1'b0;
      unique case (w_state)
         W_IDLE: begin
            wa_ready = 1'b1;
            wd_ready = 1'b1;
            if (wa_valid && wd_valid) begin
               w_next = W_RESP;
            end else if (wa_valid) begin
               w_next = W_WAIT_DATA;
            end else if (wd_valid) begin
               w_next = W_WAIT_ADDR;
            end
         end
         W_WAIT_DATA: begin
            wd_ready = 1'b1;
            if (wd_valid) begin
               w_next = W_RESP;
            end
         end
         W_WAIT_ADDR: begin
            wa_ready = 1'b1;
            if (wa_valid) begin
               w_next = W_RESP;
            end
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (b_ready) begin
               w_next = W_IDLE;
            end
         end
         default: w_next = W_IDLE;
      endcase
   end

   assign commit = (w_next == W_RESP) && (w_state != W_RESP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_state  <= W_IDLE;
         cap_addr <= '0;
         cap_data <= '0;
         cap_strb <= 1'b0;
         b_resp_q <= RESP_OKAY;
      end else begin
         w_state <= w_next;
         if (wa_hs) begin
            cap_addr <= wa_addr;
         end
         if (wd_hs) begin
            cap_data <= wd_data;
            cap_strb <= wd_strb;
         end
         if (commit) begin
            b_resp_q <= write_resp(eff_strb, eff_addr);
         end
      end
   end

   assign b_response = b_resp_q;

   // ----------------------------------------------------------------- read --
   r_state_t          r_state, r_next;
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] rf_rdata;
   logic              ra_hs;

   assign ra_ready = (r_state == R_IDLE);
   assign rd_valid = (r_state == R_DATA);
   assign ra_hs    = ra_valid && ra_ready;

   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE:  if (ra_valid) r_next = R_DATA;
         R_DATA:  if (rd_ready) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // The register file read port is combinational on current contents, so a
   // read captured on a commit edge returns the value from before the write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= R_IDLE;
         rd_data_q <= '0;
      end else begin
         r_state <= r_next;
         if (ra_hs) begin
            rd_data_q <= rf_rdata;
         end
      end
   end

   assign rd_data     = rd_data_q;
   assign rd_response = RESP_OKAY;

   // -------------------------------------------------------------- storage --
   axi_slave_regfile u_regfile (
      .clk   (clk),
      .reset (reset),
      .we    (commit && eff_strb),
      .waddr (eff_addr),
      .wdata (eff_data),
      .raddr (ra_addr),
      .rdata (rf_rdata)
   );

endmodule

// File: tb/tb_axi_slave.sv
// ----------------------------------------------------------------------------
// tb_axi_slave
// Self-checking bench for axi_slave: reset values, a table of directed
// write/read-back vectors, hand-written corner sequences and a randomized
// phase checked against an array model of the register map.
// ----------------------------------------------------------------------------
module tb_axi_slave;

   logic       clk = 1'b0;
   logic       reset;
   logic       wa_valid, wd_valid, wd_strb, b_ready, ra_valid, rd_ready;
   logic [2:0] wa_addr, ra_addr;
   logic [3:0] wd_data;
   logic       wa_ready, wd_ready, b_valid, b_response, ra_ready, rd_valid, rd_response;
   logic [3:0] rd_data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] model [8];

   axi_slave dut (
      .clk         (clk),
      .reset       (reset),
      .wa_valid    (wa_valid),
      .wa_addr     (wa_addr),
      .wa_ready    (wa_ready),
      .wd_valid    (wd_valid),
      .wd_data     (wd_data),
      .wd_strb     (wd_strb),
      .wd_ready    (wd_ready),
      .b_valid     (b_valid),
      .b_response  (b_response),
      .b_ready     (b_ready),
      .ra_valid    (ra_valid),
      .ra_addr     (ra_addr),
      .ra_ready    (ra_ready),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .rd_response (rd_response),
      .rd_ready    (rd_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] addr;
      logic [3:0] data;
      logic       strb;
      int         mode;      // 0 same cycle, 1 address first, 2 data first
      int         gap;       // idle cycles before the second channel
      int         bhold;     // cycles b_ready is held low
      int         rhold;     // cycles rd_ready is held low
      logic       exp_resp;
      logic [3:0] exp_rd;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] model_read(input logic [2:0] a);
      return (a == 3'd7) ? 4'hA : model[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 8; i++) model[i] = 4'h0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".wa_ready"},    wa_ready,    1);
      check({tag, ".wd_ready"},    wd_ready,    1);
      check({tag, ".ra_ready"},    ra_ready,    1);
      check({tag, ".b_valid"},     b_valid,     0);
      check({tag, ".b_response"},  b_response,  0);
      check({tag, ".rd_valid"},    rd_valid,    0);
      check({tag, ".rd_data"},     rd_data,     0);
      check({tag, ".rd_response"}, rd_response, 0);
   endtask

   // Full write transaction with selectable channel ordering; the response
   // is expected on the cycle after the last handshake.
   task automatic write_txn(input logic [2:0] addr, input logic [3:0] data, input logic strb,
                            input int mode, input int gap, input int bhold, input logic exp_resp);
      bit a_pend = 1, d_pend = 1;
      bit a_hs, d_hs;
      int cyc = 0;
      wa_addr  = addr;
      wd_data  = data;
      wd_strb  = strb;
      b_ready  = 1'b0;
      wa_valid = (mode != 2);
      wd_valid = (mode != 1);
      while ((a_pend || d_pend) && cyc < 30) begin
         if (!a_pend && d_pend) begin
            check("wait_data.wa_ready", wa_ready, 0);
            check("wait_data.wd_ready", wd_ready, 1);
         end else if (a_pend && !d_pend) begin
            check("wait_addr.wa_ready", wa_ready, 1);
            check("wait_addr.wd_ready", wd_ready, 0);
         end
         a_hs = wa_valid && wa_ready;
         d_hs = wd_valid && wd_ready;
         tick();
         cyc++;
         if (a_hs) begin a_pend = 0; wa_valid = 1'b0; end
         if (d_hs) begin d_pend = 0; wd_valid = 1'b0; end
         if (mode == 1 && !a_pend && d_pend && cyc >= 1 + gap) wd_valid = 1'b1;
         if (mode == 2 && !d_pend && a_pend && cyc >= 1 + gap) wa_valid = 1'b1;
      end
      wa_valid = 1'b0;
      wd_valid = 1'b0;
      check("write.handshakes_done", {a_pend, d_pend}, 0);
      check("write.b_valid", b_valid, 1);
      check("write.b_response", b_response, exp_resp);
      for (int i = 0; i < bhold; i++) begin
         tick();
         check("bhold.b_valid", b_valid, 1);
         check("bhold.b_response", b_response, exp_resp);
         check("bhold.wa_ready", wa_ready, 0);
         check("bhold.wd_ready", wd_ready, 0);
      end
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      check("write.b_valid_drop", b_valid, 0);
      check("write.wa_ready_back", wa_ready, 1);
      check("write.wd_ready_back", wd_ready, 1);
      if (strb && addr != 3'd7) model[addr] = data;
   endtask

   task automatic read_txn(input logic [2:0] addr, input int rhold, input logic [3:0] exp);
      ra_addr  = addr;
      ra_valid = 1'b1;
      rd_ready = 1'b0;
      check("read.ra_ready", ra_ready, 1);
      tick();
      ra_valid = 1'b0;
      check("read.rd_valid", rd_valid, 1);
      check("read.rd_data", rd_data, exp);
      check("read.rd_response", rd_response, 0);
      check("read.ra_ready_low", ra_ready, 0);
      for (int i = 0; i < rhold; i++) begin
         tick();
         check("rhold.rd_valid", rd_valid, 1);
         check("rhold.rd_data", rd_data, exp);
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      check("read.rd_valid_drop", rd_valid, 0);
      check("read.ra_ready_back", ra_ready, 1);
   endtask

   initial begin
      logic [2:0] a;
      logic [3:0] d;
      logic       s;

      reset = 1'b1;
      wa_valid = 0; wd_valid = 0; ra_valid = 0; b_ready = 0; rd_ready = 0;
      wa_addr = 0; wd_data = 0; wd_strb = 0; ra_addr = 0;
      clear_model();

      vecs[0] = '{addr: 3'd3, data: 4'h5, strb: 1, mode: 0, gap: 0, bhold: 0, rhold: 0, exp_resp: 0, exp_rd: 4'h5};
      vecs[1] = '{addr: 3'd2, data: 4'h9, strb: 1, mode: 2, gap: 2, bhold: 0, rhold: 0, exp_resp: 0, exp_rd: 4'h9};
      vecs[2] = '{addr: 3'd7, data: 4'h3, strb: 1, mode: 0, gap: 0, bhold: 0, rhold: 0, exp_resp: 1, exp_rd: 4'hA};
      vecs[3] = '{addr: 3'd1, data: 4'h6, strb: 0, mode: 1, gap: 1, bhold: 0, rhold: 0, exp_resp: 1, exp_rd: 4'h0};
      vecs[4] = '{addr: 3'd5, data: 4'h7, strb: 1, mode: 0, gap: 0, bhold: 5, rhold: 4, exp_resp: 0, exp_rd: 4'h7};
      vecs[5] = '{addr: 3'd6, data: 4'hC, strb: 1, mode: 1, gap: 0, bhold: 1, rhold: 2, exp_resp: 0, exp_rd: 4'hC};

      // Reset values, while asserted and after release.
      #12;
      check_idle_outputs("in_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      check_idle_outputs("after_reset");

      // Write to addr 4 commits on the same edge as a read of addr 4.
      wa_addr = 3'd4; wd_data = 4'hF; wd_strb = 1'b1; ra_addr = 3'd4;
      wa_valid = 1; wd_valid = 1; ra_valid = 1; b_ready = 0; rd_ready = 0;
      tick();
      wa_valid = 0; wd_valid = 0; ra_valid = 0;
      check("same_edge.b_valid", b_valid, 1);
      check("same_edge.b_response", b_response, 0);
      check("same_edge.rd_valid", rd_valid, 1);
      check("same_edge.rd_data_old", rd_data, 4'h0);
      b_ready = 1; rd_ready = 1;
      tick();
      b_ready = 0; rd_ready = 0;
      check("same_edge.idle_b", b_valid, 0);
      check("same_edge.idle_r", rd_valid, 0);
      model[4] = 4'hF;
      read_txn(3'd4, 0, 4'hF);

      // Directed table.
      foreach (vecs[i]) begin
         write_txn(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].mode,
                   vecs[i].gap, vecs[i].bhold, vecs[i].exp_resp);
         read_txn(vecs[i].addr, vecs[i].rhold, vecs[i].exp_rd);
         check("table.model_agrees", model_read(vecs[i].addr), vecs[i].exp_rd);
      end

      // Reset while the write FSM waits for data and the read FSM holds data.
      wa_addr = 3'd0; ra_addr = 3'd3; wa_valid = 1; ra_valid = 1; rd_ready = 0;
      tick();
      wa_valid = 0; ra_valid = 0;
      check("pre_reset.wd_only", {wa_ready, wd_ready}, 2'b01);
      check("pre_reset.rd_valid", rd_valid, 1);
      wd_data = 4'hB; wd_strb = 1'b1;
      reset = 1'b1;
      #2;
      check_idle_outputs("mid_reset");
      tick();
      reset = 1'b0;
      clear_model();
      tick();
      check_idle_outputs("post_mid_reset");
      read_txn(3'd0, 0, 4'h0);

      // Randomized traffic against the array model.
      for (int n = 0; n < 60; n++) begin
         a = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0) begin
            d = 4'($urandom_range(0, 15));
            s = ($urandom_range(0, 3) != 0);
            write_txn(a, d, s, $urandom_range(0, 2), $urandom_range(0, 3),
                      $urandom_range(0, 2), (!s || a == 3'd7));
         end else begin
            read_txn(a, $urandom_range(0, 2), model_read(a));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
